shift_counter: RTL and testbench

- Per-frame producer of the displacement statistics consumed by the shift decision logic.
- Accumulates per-block motion vectors within a frame into four saturating 5-bit direction counters (x positive/negative, y positive/negative).
- Flags whether the dominant x/y direction matches the previous frame's.
- Presents latched results with a one-cycle valid strobe at frame end.

---
 rtl/shift_pkg.sv | 30 +++
 rtl/shift_counter_if.sv | 30 +++
 rtl/shift_sat_cnt.sv | 38 +++
 rtl/shift_counter.sv | 141 ++++++++++++++
 tb/tb_shift_counter.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/shift_pkg.sv
// Shared constants, state/direction encodings and the dominant-direction helper
// for the shift_counter block.
package shift_pkg;

  localparam int CNT_W   = 5;
  localparam int CNT_MAX = 31;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    LATCH = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    POS  = 2'b01,
    NEG  = 2'b10
  } dir_t;

  function automatic dir_t dominant(input logic [CNT_W-1:0] o_cnt,
                                    input logic [CNT_W-1:0] n_cnt);
    if (o_cnt > n_cnt)
      return POS;
    else if (n_cnt > o_cnt)
      return NEG;
    else
      return NONE;
  endfunction

endpackage

// File: rtl/shift_counter_if.sv
// Frame/vector input bundle and latched statistics outputs of shift_counter.
// master = frame/vector producer, slave = shift_counter.
interface shift_counter_if
  import shift_pkg::*;
#(
  parameter int DW = 8
);
  logic                    frame_start;
  logic                    frame_end;
  logic                    vec_valid;
  logic signed [DW-1:0]    vec_dx;
  logic signed [DW-1:0]    vec_dy;
  logic [CNT_W-1:0]        dxo_cnt;
  logic [CNT_W-1:0]        dxn_cnt;
  logic [CNT_W-1:0]        dyo_cnt;
  logic [CNT_W-1:0]        dyn_cnt;
  logic                    x_same;
  logic                    y_same;
  logic                    cnt_valid;

  modport master (
    output frame_start, frame_end, vec_valid, vec_dx, vec_dy,
    input  dxo_cnt, dxn_cnt, dyo_cnt, dyn_cnt, x_same, y_same, cnt_valid
  );

  modport slave (
    input  frame_start, frame_end, vec_valid, vec_dx, vec_dy,
    output dxo_cnt, dxn_cnt, dyo_cnt, dyn_cnt, x_same, y_same, cnt_valid
  );
endinterface

// File: rtl/shift_sat_cnt.sv
// Saturating counter with clear/load/increment; clear beats load beats increment.
module shift_sat_cnt
  import shift_pkg::*;
#(
  parameter int MAX = CNT_MAX
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (clr)
      cnt_next = '0;
    else if (load)
      cnt_next = load_val;
    else if (inc && (cnt_reg < CNT_W'(MAX)))
      cnt_next = cnt_reg + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_reg <= '0;
    else
      cnt_reg <= cnt_next;
  end

  assign cnt = cnt_reg;

endmodule

// File: rtl/shift_counter.sv
// Per-frame motion-vector direction statistics with previous-frame comparison.
// Optional build macro SHIFT_CNT_DECAY_EN: counters start each frame at half the last latched counts.
module shift_counter
  import shift_pkg::*;
#(
  parameter int DW        = 8,
  parameter int DEAD_ZONE = 2,
  parameter int CNT_MAX   = shift_pkg::CNT_MAX
) (
  input  logic           clk,
  input  logic           rst_n,
  shift_counter_if.slave bus
);

  // One extra bit keeps -2^(DW-1) and -DEAD_ZONE representable in the compare.
  localparam logic signed [DW:0] DZ_POS = (DW+1)'(DEAD_ZONE);
  localparam logic signed [DW:0] DZ_NEG = -DZ_POS;

  state_t state_reg, state_next;
  logic   start_acc, acc_en, latch_en;

  logic signed [DW:0] dx_ext, dy_ext;
  logic [3:0]         inc_vec;
  logic               cnt_clr, cnt_load;

  // Index order: 0 = x pos, 1 = x neg, 2 = y pos, 3 = y neg.
  logic [CNT_W-1:0] work_cnt [4];
  logic [CNT_W-1:0] out_cnt_reg [4];

  dir_t dir_x, dir_y;
  dir_t prev_x_reg, prev_y_reg;
  logic x_same_reg, y_same_reg, cnt_valid_reg;

  always_comb begin
    state_next = state_reg;
    start_acc  = 1'b0;
    acc_en     = 1'b0;
    latch_en   = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (bus.frame_start) begin
          start_acc  = 1'b1;
          state_next = ACCUM;
        end
      end
      ACCUM: begin
        if (bus.frame_start) begin
          start_acc = 1'b1;
        end else begin
          acc_en = bus.vec_valid;
          if (bus.frame_end)
            state_next = LATCH;
        end
      end
      LATCH: begin
        latch_en   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  assign dx_ext = {bus.vec_dx[DW-1], bus.vec_dx};
  assign dy_ext = {bus.vec_dy[DW-1], bus.vec_dy};

  assign inc_vec[0] = acc_en && (dx_ext >= DZ_POS);
  assign inc_vec[1] = acc_en && (dx_ext <= DZ_NEG);
  assign inc_vec[2] = acc_en && (dy_ext >= DZ_POS);
  assign inc_vec[3] = acc_en && (dy_ext <= DZ_NEG);

`ifdef SHIFT_CNT_DECAY_EN
  assign cnt_clr  = 1'b0;
  assign cnt_load = start_acc;
`else
  assign cnt_clr  = start_acc;
  assign cnt_load = 1'b0;
`endif

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_cnt
      logic [CNT_W-1:0] load_val;
`ifdef SHIFT_CNT_DECAY_EN
      assign load_val = out_cnt_reg[gi] >> 1;
`else
      assign load_val = '0;
`endif
      shift_sat_cnt #(
        .MAX(CNT_MAX)
      ) u_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (cnt_clr),
        .load    (cnt_load),
        .load_val(load_val),
        .inc     (inc_vec[gi]),
        .cnt     (work_cnt[gi])
      );
    end
  endgenerate

  assign dir_x = dominant(work_cnt[0], work_cnt[1]);
  assign dir_y = dominant(work_cnt[2], work_cnt[3]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++)
        out_cnt_reg[i] <= '0;
      prev_x_reg    <= NONE;
      prev_y_reg    <= NONE;
      x_same_reg    <= 1'b0;
      y_same_reg    <= 1'b0;
      cnt_valid_reg <= 1'b0;
    end else begin
      cnt_valid_reg <= latch_en;
      if (latch_en) begin
        for (int i = 0; i < 4; i++)
          out_cnt_reg[i] <= work_cnt[i];
        x_same_reg <= (dir_x == prev_x_reg) && (dir_x != NONE);
        y_same_reg <= (dir_y == prev_y_reg) && (dir_y != NONE);
        prev_x_reg <= dir_x;
        prev_y_reg <= dir_y;
      end
    end
  end

  assign bus.dxo_cnt   = out_cnt_reg[0];
  assign bus.dxn_cnt   = out_cnt_reg[1];
  assign bus.dyo_cnt   = out_cnt_reg[2];
  assign bus.dyn_cnt   = out_cnt_reg[3];
  assign bus.x_same    = x_same_reg;
  assign bus.y_same    = y_same_reg;
  assign bus.cnt_valid = cnt_valid_reg;

endmodule

// File: tb/tb_shift_counter.sv
// Directed plus randomized frames for shift_counter, checked against a counting model.
module tb_shift_counter;

  localparam int DW  = 8;
  localparam int DZ  = 2;
  localparam int MAX = 31;

  logic clk = 1'b0;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;

  int m_cnt [4];
  int m_out [4];
  int m_prev_x, m_prev_y, m_xs, m_ys;

  shift_counter_if #(.DW(DW)) bus ();

  shift_counter #(
    .DW(DW), .DEAD_ZONE(DZ), .CNT_MAX(MAX)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish within time budget");
    $fatal(1, "timeout");
  end

  function automatic int dir_of(input int o, input int n);
    return (o > n) ? 1 : ((n > o) ? 2 : 0);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_cnt[i] = 0;
      m_out[i] = 0;
    end
    m_prev_x = 0; m_prev_y = 0; m_xs = 0; m_ys = 0;
  endtask

  task automatic model_start();
    for (int i = 0; i < 4; i++) begin
`ifdef SHIFT_CNT_DECAY_EN
      m_cnt[i] = m_out[i] / 2;
`else
      m_cnt[i] = 0;
`endif
    end
  endtask

  task automatic model_vec(input int dx, input int dy);
    if (dx >= DZ)       m_cnt[0] = (m_cnt[0] + 1 > MAX) ? MAX : m_cnt[0] + 1;
    else if (dx <= -DZ) m_cnt[1] = (m_cnt[1] + 1 > MAX) ? MAX : m_cnt[1] + 1;
    if (dy >= DZ)       m_cnt[2] = (m_cnt[2] + 1 > MAX) ? MAX : m_cnt[2] + 1;
    else if (dy <= -DZ) m_cnt[3] = (m_cnt[3] + 1 > MAX) ? MAX : m_cnt[3] + 1;
  endtask

  task automatic model_latch();
    int dx_dir, dy_dir;
    dx_dir = dir_of(m_cnt[0], m_cnt[1]);
    dy_dir = dir_of(m_cnt[2], m_cnt[3]);
    m_xs = (dx_dir != 0 && dx_dir == m_prev_x) ? 1 : 0;
    m_ys = (dy_dir != 0 && dy_dir == m_prev_y) ? 1 : 0;
    m_prev_x = dx_dir;
    m_prev_y = dy_dir;
    for (int i = 0; i < 4; i++) m_out[i] = m_cnt[i];
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int exp_valid);
    chk({tag, ".cnt_valid"}, int'(bus.cnt_valid), exp_valid);
    chk({tag, ".dxo_cnt"},   int'(bus.dxo_cnt),   m_out[0]);
    chk({tag, ".dxn_cnt"},   int'(bus.dxn_cnt),   m_out[1]);
    chk({tag, ".dyo_cnt"},   int'(bus.dyo_cnt),   m_out[2]);
    chk({tag, ".dyn_cnt"},   int'(bus.dyn_cnt),   m_out[3]);
    chk({tag, ".x_same"},    int'(bus.x_same),    m_xs);
    chk({tag, ".y_same"},    int'(bus.y_same),    m_ys);
  endtask

  task automatic tick();
    @(negedge clk);
    bus.frame_start = 1'b0;
    bus.frame_end   = 1'b0;
    bus.vec_valid   = 1'b0;
    bus.vec_dx      = '0;
    bus.vec_dy      = '0;
  endtask

  task automatic start_frame();
    tick();
    bus.frame_start = 1'b1;
    model_start();
  endtask

  task automatic send_vec(input int dx, input int dy);
    tick();
    bus.vec_valid = 1'b1;
    bus.vec_dx    = DW'(dx);
    bus.vec_dy    = DW'(dy);
    model_vec(dx, dy);
  endtask

  task automatic end_frame(input string tag, input bit with_vec, input int dx, input int dy);
    tick();
    bus.frame_end = 1'b1;
    if (with_vec) begin
      bus.vec_valid = 1'b1;
      bus.vec_dx    = DW'(dx);
      bus.vec_dy    = DW'(dy);
      model_vec(dx, dy);
    end
    tick();
    chk({tag, ".latch_cycle_valid"}, int'(bus.cnt_valid), 0);
    model_latch();
    tick();
    check_outs(tag, 1);
    tick();
    check_outs({tag, ".hold"}, 0);
    $display("frame %s: dxo=%0d dxn=%0d dyo=%0d dyn=%0d x_same=%0d y_same=%0d",
             tag, m_out[0], m_out[1], m_out[2], m_out[3], m_xs, m_ys);
  endtask

  function automatic int rand_comp();
    if ($urandom_range(0, 3) == 0)
      return int'($urandom_range(0, 255)) - 128;
    return int'($urandom_range(0, 8)) - 4;
  endfunction

  initial begin
    rst_n           = 1'b0;
    bus.frame_start = 1'b0;
    bus.frame_end   = 1'b0;
    bus.vec_valid   = 1'b0;
    bus.vec_dx      = '0;
    bus.vec_dy      = '0;
    model_reset();
    #1;
    check_outs("reset", 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_outs("post_reset", 0);

    // Basic frame: +5,+5,-1 on x
    start_frame();
    send_vec(5, 0); send_vec(5, 0); send_vec(-1, 0);
    end_frame("basic", 1'b0, 0, 0);
    chk("basic.dxo_expect2", int'(bus.dxo_cnt), 2);

    // Two consecutive -4 frames
    for (int f = 0; f < 2; f++) begin
      start_frame();
      for (int k = 0; k < 4; k++) send_vec(-4, 0);
      end_frame(f == 0 ? "neg_a" : "neg_b", 1'b0, 0, 0);
    end
    chk("neg_b.x_same_expect1", int'(bus.x_same), 1);

    // Saturation
    start_frame();
    for (int k = 0; k < 40; k++) send_vec(0, 3);
    end_frame("saturate", 1'b0, 0, 0);
    chk("saturate.dyo_expect31", int'(bus.dyo_cnt), 31);

    // Dead-zone edge and most-negative value
    start_frame();
    send_vec(DZ - 1, 0); send_vec(-128, 0);
    end_frame("edge", 1'b0, 0, 0);

    // Vector on the frame_end cycle
    start_frame();
    send_vec(7, -7);
    end_frame("vec_on_end", 1'b1, 9, -9);

    // Abort mid-frame, then frame_start together with frame_end
    start_frame();
    send_vec(6, 6); send_vec(6, 6); send_vec(6, 6);
    start_frame();
    tick(); chk("abort.no_valid", int'(bus.cnt_valid), 0);
    send_vec(-6, 3);
    tick();
    bus.frame_start = 1'b1;
    bus.frame_end   = 1'b1;
    model_start();
    tick(); chk("start_end.no_valid_a", int'(bus.cnt_valid), 0);
    tick(); chk("start_end.no_valid_b", int'(bus.cnt_valid), 0);
    send_vec(-3, 4);
    end_frame("abort", 1'b0, 0, 0);

    // Ignored inputs while idle
    tick(); bus.vec_valid = 1'b1; bus.vec_dx = 8'sd50; bus.vec_dy = -8'sd50;
    tick(); bus.frame_end = 1'b1;
    tick(); chk("idle_end.no_valid_a", int'(bus.cnt_valid), 0);
    tick(); check_outs("idle_end.no_valid_b", 0);

    // Ten x-positive vectors followed by an empty frame
    start_frame();
    for (int k = 0; k < 10; k++) send_vec(3, 0);
    end_frame("ten_pos", 1'b0, 0, 0);
    start_frame();
    end_frame("empty_after_ten", 1'b0, 0, 0);

    // Randomized frames
    for (int f = 0; f < 25; f++) begin
      int nvec;
      start_frame();
      nvec = int'($urandom_range(0, 45));
      for (int k = 0; k < nvec; k++) begin
        if ($urandom_range(0, 4) == 0) tick();
        send_vec(rand_comp(), rand_comp());
      end
      end_frame($sformatf("rand%0d", f), bit'($urandom_range(0, 1)), rand_comp(), rand_comp());
      repeat ($urandom_range(0, 2)) begin
        tick();
        bus.vec_valid = 1'b1;
        bus.vec_dx    = DW'(rand_comp());
      end
    end

    // Reset in the middle of accumulation
    start_frame();
    for (int k = 0; k < 5; k++) send_vec(4, -4);
    tick();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outs("mid_reset", 0);
    tick();
    rst_n = 1'b1;
    start_frame();
    send_vec(2, -2); send_vec(2, 2);
    end_frame("after_reset", 1'b0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
